// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo: pointer sizing, parameter legality and reset values.
package sync_fifo_pkg;

   localparam logic RST_EMPTY        = 1'b1;
   localparam logic RST_FULL         = 1'b0;
   localparam logic RST_RD_VALID     = 1'b0;
   localparam logic RST_ERR_FLAG     = 1'b0;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   function automatic bit params_ok(input int depth, input int add_w,
                                    input int afull, input int aempty);
      return is_pow2(depth) && (depth >= 4) && (add_w == $clog2(depth)) &&
             (afull >= 1) && (afull <= depth) &&
             (aempty >= 0) && (aempty <= depth - 1);
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port storage for sync_fifo: synchronous write, combinational read; contents are never reset.
module sync_fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 16,
   parameter int ADD_WIDTH  = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADD_WIDTH-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADD_WIDTH-1:0]  raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int MEM_DEPTH     = 16,
   parameter int ADD_WIDTH     = $clog2(MEM_DEPTH),
   parameter int AFULL_THRESH  = MEM_DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_inc,
   input  logic                  rd_inc,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADD_WIDTH:0]    level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int PTR_W = ADD_WIDTH + 1;
   localparam logic [ADD_WIDTH:0] AF_LVL = PTR_W'(AFULL_THRESH);
   localparam logic [ADD_WIDTH:0] AE_LVL = PTR_W'(AEMPTY_THRESH);

   if (!params_ok(MEM_DEPTH, ADD_WIDTH, AFULL_THRESH, AEMPTY_THRESH) ||
       ptr_width(MEM_DEPTH) != PTR_W) begin : g_bad_params
      $error("sync_fifo: illegal depth, address width or threshold parameters");
   end

   logic [ADD_WIDTH:0]    wr_ptr;
   logic [ADD_WIDTH:0]    rd_ptr;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  wr_acc;
   logic                  rd_acc;

   // Handshake: wr_inc/rd_inc are requests; a request is accepted on the edge
   // where it is high and the FIFO is not full (write) / not empty (read).
   // No pass-through: a full FIFO refuses writes even while a read drains it.
   assign wr_acc = wr_inc && !full;
   assign rd_acc = rd_inc && !empty;

   assign full  = (wr_ptr[ADD_WIDTH] != rd_ptr[ADD_WIDTH]) &&
                  (wr_ptr[ADD_WIDTH-1:0] == rd_ptr[ADD_WIDTH-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign level = wr_ptr - rd_ptr;
   assign almost_full  = (level >= AF_LVL);
   assign almost_empty = (level <= AE_LVL);

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .ADD_WIDTH  (ADD_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc && !rst),
      .waddr (wr_ptr[ADD_WIDTH-1:0]),
      .wdata (wr_data),
      .raddr (rd_ptr[ADD_WIDTH-1:0]),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= RST_ERR_FLAG;
         underflow <= RST_ERR_FLAG;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         // A fresh rejection wins over a coincident clear.
         if (wr_inc && full)  overflow  <= 1'b1;
         else if (err_clr)    overflow  <= 1'b0;
         if (rd_inc && empty) underflow <= 1'b1;
         else if (err_clr)    underflow <= 1'b0;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rd_data  = mem_rdata;
   assign rd_valid = !empty;
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= RST_RD_VALID;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) rd_data <= mem_rdata;
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with a queue-based reference model and literal spot checks.
module tb_sync_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int AF    = DEPTH - 2;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] wr_data;
   logic          wr_inc;
   logic          rd_inc;
   logic          err_clr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   level;
   logic          overflow;
   logic          underflow;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // reference model state
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_rd_data = '0;
   logic          exp_rd_valid = 1'b0;
   logic          exp_ovf = 1'b0;
   logic          exp_unf = 1'b0;

   sync_fifo dut (
      .clk          (clk),
      .rst          (rst),
      .wr_data      (wr_data),
      .wr_inc       (wr_inc),
      .rd_inc       (rd_inc),
      .err_clr      (err_clr),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .level        (level),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: occupancy is the queue size, reads pop its head
   always @(posedge clk) begin
      bit was_full;
      bit was_empty;
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      if (rst) begin
         exp_q.delete();
         exp_rd_data  = '0;
         exp_rd_valid = 1'b0;
         exp_ovf      = 1'b0;
         exp_unf      = 1'b0;
      end else begin
         if (wr_inc && was_full) exp_ovf = 1'b1;
         else if (err_clr)       exp_ovf = 1'b0;
         if (rd_inc && was_empty) exp_unf = 1'b1;
         else if (err_clr)        exp_unf = 1'b0;
         exp_rd_valid = 1'b0;
         if (rd_inc && !was_empty) begin
            exp_rd_data  = exp_q.pop_front();
            exp_rd_valid = 1'b1;
         end
         if (wr_inc && !was_full) exp_q.push_back(wr_data);
      end
   end

   // compare process, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("level",        32'(level),        32'(exp_q.size()));
         check("full",         32'(full),         32'(exp_q.size() == DEPTH));
         check("empty",        32'(empty),        32'(exp_q.size() == 0));
         check("almost_full",  32'(almost_full),  32'(exp_q.size() >= AF));
         check("almost_empty", 32'(almost_empty), 32'(exp_q.size() <= AE));
         check("overflow",     32'(overflow),     32'(exp_ovf));
         check("underflow",    32'(underflow),    32'(exp_unf));
`ifdef SYNC_FIFO_FWFT_EN
         check("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) check("rd_data", 32'(rd_data), 32'(exp_q[0]));
`else
         check("rd_valid", 32'(rd_valid), 32'(exp_rd_valid));
         check("rd_data",  32'(rd_data),  32'(exp_rd_data));
`endif
      end
   end

   // driver: apply one cycle of requests starting from a negedge
   task automatic drive(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
      wr_inc  = w;
      rd_inc  = r;
      wr_data = d;
      err_clr = c;
      @(negedge clk);
      wr_inc  = 1'b0;
      rd_inc  = 1'b0;
      err_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_inc = 1'b0; rd_inc = 1'b0; err_clr = 1'b0; wr_data = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst = 1'b0;
      check("rst_level", 32'(level), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_aempty", 32'(almost_empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);

`ifdef SYNC_FIFO_FWFT_EN
      drive(1'b1, 1'b0, 8'hA5, 1'b0);
      check("fwft_data", 32'(rd_data), 32'hA5);
      check("fwft_valid", 32'(rd_valid), 32'd1);
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      check("fwft_pop_empty", 32'(empty), 32'd1);
`endif

      // fill 0x00..0x0F
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'b0, DW'(i), 1'b0);
         check("fill_level", 32'(level), 32'(i + 1));
         check("fill_afull", 32'(almost_full), 32'(i + 1 >= 14));
      end
      check("fill_full", 32'(full), 32'd1);
      drive(1'b1, 1'b0, 8'hEE, 1'b0);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_level", 32'(level), 32'd16);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("ovf_clr", 32'(overflow), 32'd0);

      // drain in order
      for (int i = 0; i < DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         check("drain_head", 32'(rd_data), 32'(i));
         drive(1'b0, 1'b1, 8'h00, 1'b0);
`else
         drive(1'b0, 1'b1, 8'h00, 1'b0);
         check("drain_data", 32'(rd_data), 32'(i));
         check("drain_valid", 32'(rd_valid), 32'd1);
`endif
      end
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      check("unf_set", 32'(underflow), 32'd1);
      check("unf_empty", 32'(empty), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
      check("unf_valid", 32'(rd_valid), 32'd0);
      check("unf_hold", 32'(rd_data), 32'h0F);
`endif
      // clear coincident with a new rejection keeps the flag
      drive(1'b0, 1'b1, 8'h00, 1'b1);
      check("unf_clr_race", 32'(underflow), 32'd1);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("unf_clr", 32'(underflow), 32'd0);

      // steady read/write at level 8, pointers wrap
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, DW'(8'h20 + i), 1'b0);
      for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, DW'(8'h40 + i), 1'b0);
      check("steady_level", 32'(level), 32'd8);

      // fill to full, then simultaneous request
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, DW'(8'h80 + i), 1'b0);
      check("full_again", 32'(full), 32'd1);
      drive(1'b1, 1'b1, 8'hCC, 1'b0);
      check("simul_level", 32'(level), 32'd15);
      check("simul_ovf", 32'(overflow), 32'd1);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("simul_ovf_clr", 32'(overflow), 32'd0);

      // a short random mix to sweep almost-thresholds both ways
      for (int i = 0; i < 60; i++)
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               DW'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0));

      // reset mid-operation at level 5 with a write pending
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DW'(8'h50 + i), 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 8'h55, 1'b0);
`endif
      check("pre_rst_level", 32'(level), 32'd5);
      rst = 1'b1;
      drive(1'b1, 1'b1, 8'h77, 1'b0);
      rst = 1'b0;
      check("rst_mid_level", 32'(level), 32'd0);
      check("rst_mid_empty", 32'(empty), 32'd1);
      check("rst_mid_data", 32'(rd_data), 32'd0);
      check("rst_mid_ovf", 32'(overflow), 32'd0);
      check("rst_mid_unf", 32'(underflow), 32'd0);

      drive(1'b0, 1'b0, 8'h00, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
